eth_measurer_rx: RTL and testbench
==================================

# eth_measurer_rx

Receive-side frame decoder for the Ethernet latency measurer. It watches one MAC receive byte stream and recognises measurement frames: destination MAC match, measurer EtherType, error-free, minimum length. From each accepted frame it extracts the 64-bit ping identifier and presents it to the measurement coordinator as `rx_ping_id`. One instance sits on the main interface and drives `main_rx_ping_id`; a second sits on the loopback interface and drives `loop_rx_ping_id`.

## Interface
- `ETHERTYPE`, default 16'h5A42: EtherType carried by measurer frames.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mac_addr` in 48: local station address. Byte 0 on the wire is `mac_addr[47:40]`.
- `s_axis_tdata` in 8: received byte.
- `s_axis_tvalid` in 1: byte valid. There is no `tready`; the block always accepts.
- `s_axis_tlast` in 1: last byte of the frame, FCS already stripped.
- `s_axis_tuser` in 1: MAC error flag (FCS or PHY error). Sampled only on the `tlast` beat.
- `rx_ping_id` out 64: identifier of the last accepted frame.
- `rx_done` out 1: one-cycle pulse when `rx_ping_id` updates.
- `rx_frames_good` out 64: count of accepted frames.
- `rx_frames_bad` out 64: count of addressed frames rejected for error or length.

## Operation
- Frame layout, counted from byte 0:
  - bytes 0–5: destination MAC;
  - bytes 6–11: source MAC, ignored;
  - bytes 12–13: EtherType, big-endian;
  - bytes 14–21: ping_id, big-endian; byte 14 goes to bits 63:56;
  - remaining bytes: padding, ignored.
- Byte counter `idx`, 16 bits:
  - increments on each valid beat;
  - saturates at 16'hFFFF;
  - clears on the beat after a `tlast`.
- Destination matches if the 6 bytes equal `mac_addr` or all equal 8'hFF (broadcast).
- States:
  - **ST_HEADER**: compare bytes 0–13 on the fly.
    - Any mismatch → ST_DROP.
    - `tlast` seen during bytes 0–13 → back to ST_HEADER, nothing counted. The header was never fully matched, so the frame is not addressed.
    - Byte 13 matches → ST_ID.
  - **ST_ID**: shift bytes 14–21 into a capture register `id_cap`.
    - After byte 21 → ST_PAD.
    - `tlast` in this state → runt. Increment `rx_frames_bad`, go to ST_HEADER.
  - **ST_PAD**: wait for `tlast`, then evaluate the frame:
    - accept if `tuser`=0 and total length ≥ 60 bytes (14 header + 46 minimum payload);
    - on accept: `rx_ping_id` ← `id_cap`, pulse `rx_done`, increment `rx_frames_good`;
    - otherwise increment `rx_frames_bad`;
    - in both cases go to ST_HEADER.
  - **ST_DROP**: wait for `tlast` → ST_HEADER. No counters change.
  - Illegal state encoding → ST_HEADER.
- `rx_ping_id` changes only on an accepted frame. A later bad frame never corrupts it.
- Counters are 64-bit and wrap modulo 2^64.
- `tvalid`=0 beats are ignored entirely: no state change, `idx` holds.

## Timing
- Reset values:
  - `rx_ping_id` = 64'hFFFF_FFFF_FFFF_FFFF. This must not equal the coordinator's initial ping_id of 0, so no false match after reset.
  - `rx_done` = 0.
  - both counters = 0.
  - state = ST_HEADER, `idx` = 0, `id_cap` = 0.
- Latency: `rx_ping_id`, `rx_done` and `rx_frames_good` update on the clock edge after the `tlast` beat, i.e. 1 cycle.
- `rx_done` is high for exactly 1 cycle per accepted frame.
- Back-to-back frames, with `tvalid` continuously high and byte 0 of the next frame on the cycle after `tlast`, must be fully parsed with no lost beat.
- A `tlast` beat is both "end of current frame" and "last byte counted toward length".
- Reset mid-frame:
  - all state returns to reset values on the next edge;
  - the tail of the interrupted frame is parsed as a new frame;
  - the tail is accepted only if it happens to form a fully valid header, so real traffic rejects it.
- `rst` has priority over every stream event in the same cycle.

## Structure
- Shared package `eth_measurer_pkg` holds:
  - `ETH_HDR_LEN` = 14;
  - `ETH_MIN_FRAME` = 60;
  - `PING_ID_OFFSET` = 14;
  - `PING_ID_LEN` = 8;
  - the default EtherType constant;
  - the receiver state enum `{ST_HEADER, ST_ID, ST_PAD, ST_DROP}`.
- The transmitter must reuse the same package so both ends share the frame layout.
- One sub-module is natural: `eth_hdr_match`. It takes `idx`, the byte, `mac_addr` and `ETHERTYPE`, and outputs a per-beat mismatch flag. It is combinational and is instantiated once.

## Test plan
- **Reset output**: reset, then idle 10 cycles → `rx_ping_id`=all-ones, counters 0, `rx_done` never high.
- **Good unicast frame**: 60-byte frame to `mac_addr`=02:00:00:00:00:01, EtherType 5A42, id 64'h0000_0000_0000_0007, `tuser`=0 → one cycle after `tlast`: `rx_ping_id`=7, `rx_done` pulse, `rx_frames_good`=1.
- **Error flag**: same frame with `tuser`=1 on `tlast` → `rx_ping_id` stays 7, `rx_frames_bad`=1, no `rx_done`.
- **Filtering**:
  - wrong EtherType 0800 → all counters unchanged;
  - broadcast destination with id 9 → `rx_ping_id`=9;
  - 40-byte addressed runt → `rx_frames_bad`+1.
- **Stream robustness**: three back-to-back frames with random `tvalid` gaps, ids 10, 11, 12 → three `rx_done` pulses; final `rx_ping_id`=12, `rx_frames_good`+3.
- **Reset mid-frame**: assert `rst` at byte 17 of a frame, then send a good frame with id 20 → reset values after `rst`; the tail is ignored; `rx_ping_id`=20, `rx_frames_good`=1.

Source files
------------

// File: rtl/eth_measurer_pkg.sv
// Frame layout constants and receiver state type shared by the measurer's transmit and receive sides.
package eth_measurer_pkg;

  localparam int unsigned ETH_MAC_LEN       = 6;
  localparam int unsigned ETH_ETYPE_OFFSET  = 12;
  localparam int unsigned ETH_HDR_LEN       = 14;
  localparam int unsigned ETH_MIN_FRAME     = 60;
  localparam int unsigned PING_ID_OFFSET    = 14;
  localparam int unsigned PING_ID_LEN       = 8;
  localparam logic [15:0] ETHERTYPE_DEFAULT = 16'h5A42;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_ID     = 2'd1,
    ST_PAD    = 2'd2,
    ST_DROP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/eth_hdr_match.sv
// Per-beat header comparator: checks destination MAC (unicast or broadcast) and EtherType bytes.
module eth_hdr_match
  import eth_measurer_pkg::*;
(
  input  logic [15:0] idx_i,
  input  logic [7:0]  byte_i,
  input  logic [47:0] mac_addr_i,
  input  logic [15:0] ethertype_i,
  input  logic        ucast_ok_i,
  input  logic        bcast_ok_i,
  output logic        ucast_ok_o,
  output logic        bcast_ok_o,
  output logic        mismatch_o
);

  logic       first;
  logic [7:0] mac_byte;

  always_comb begin
    mac_byte = 8'h00;
    case (idx_i)
      16'd0:   mac_byte = mac_addr_i[47:40];
      16'd1:   mac_byte = mac_addr_i[39:32];
      16'd2:   mac_byte = mac_addr_i[31:24];
      16'd3:   mac_byte = mac_addr_i[23:16];
      16'd4:   mac_byte = mac_addr_i[15:8];
      16'd5:   mac_byte = mac_addr_i[7:0];
      default: mac_byte = 8'h00;
    endcase
  end

  // Unicast and broadcast must each hold for all six bytes; mixing the two is a miss.
  assign first      = (idx_i == 16'd0);
  assign ucast_ok_o = (first | ucast_ok_i) & (byte_i == mac_byte);
  assign bcast_ok_o = (first | bcast_ok_i) & (byte_i == 8'hFF);

  always_comb begin
    mismatch_o = 1'b0;
    if (idx_i < 16'(ETH_MAC_LEN))
      mismatch_o = ~(ucast_ok_o | bcast_ok_o);
    else if (idx_i == 16'(ETH_ETYPE_OFFSET))
      mismatch_o = (byte_i != ethertype_i[15:8]);
    else if (idx_i == 16'(ETH_ETYPE_OFFSET + 1))
      mismatch_o = (byte_i != ethertype_i[7:0]);
  end

endmodule

// File: rtl/eth_measurer_rx.sv
// Receive-side measurement frame decoder: filters addressed measurer frames and extracts the 64-bit ping id.
module eth_measurer_rx
  import eth_measurer_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] mac_addr,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [63:0] rx_ping_id,
  output logic        rx_done,
  output logic [63:0] rx_frames_good,
  output logic [63:0] rx_frames_bad
);

  rx_state_t   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [63:0] id_cap_q, id_cap_d;
  logic [63:0] ping_id_q, ping_id_d;
  logic [63:0] good_q, good_d;
  logic [63:0] bad_q, bad_d;
  logic        done_q, done_d;
  logic        ucast_ok_q, ucast_ok_d;
  logic        bcast_ok_q, bcast_ok_d;
  logic        ucast_ok, bcast_ok, mismatch;

  eth_hdr_match u_hdr_match (
    .idx_i       (idx_q),
    .byte_i      (s_axis_tdata),
    .mac_addr_i  (mac_addr),
    .ethertype_i (ETHERTYPE),
    .ucast_ok_i  (ucast_ok_q),
    .bcast_ok_i  (bcast_ok_q),
    .ucast_ok_o  (ucast_ok),
    .bcast_ok_o  (bcast_ok),
    .mismatch_o  (mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HEADER;
      idx_q      <= '0;
      id_cap_q   <= '0;
      ping_id_q  <= '1;
      good_q     <= '0;
      bad_q      <= '0;
      done_q     <= 1'b0;
      ucast_ok_q <= 1'b0;
      bcast_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      id_cap_q   <= id_cap_d;
      ping_id_q  <= ping_id_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      done_q     <= done_d;
      ucast_ok_q <= ucast_ok_d;
      bcast_ok_q <= bcast_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    id_cap_d   = id_cap_q;
    ping_id_d  = ping_id_q;
    good_d     = good_q;
    bad_d      = bad_q;
    done_d     = 1'b0;
    ucast_ok_d = ucast_ok_q;
    bcast_ok_d = bcast_ok_q;
    if (s_axis_tvalid) begin
      if (s_axis_tlast)
        idx_d = '0;
      else if (idx_q != 16'hFFFF)
        idx_d = idx_q + 16'd1;
      case (state_q)
        ST_HEADER: begin
          ucast_ok_d = ucast_ok;
          bcast_ok_d = bcast_ok;
          // A frame ending inside the header was never addressed, so it is not counted.
          if (s_axis_tlast)
            state_d = ST_HEADER;
          else if (mismatch)
            state_d = ST_DROP;
          else if (idx_q == 16'(ETH_HDR_LEN - 1))
            state_d = ST_ID;
        end
        ST_ID: begin
          id_cap_d = {id_cap_q[55:0], s_axis_tdata};
          if (s_axis_tlast) begin
            bad_d   = bad_q + 64'd1;
            state_d = ST_HEADER;
          end else if (idx_q == 16'(PING_ID_OFFSET + PING_ID_LEN - 1)) begin
            state_d = ST_PAD;
          end
        end
        ST_PAD: begin
          if (s_axis_tlast) begin
            // idx is the index of the tlast byte, so frame length is idx + 1.
            if (!s_axis_tuser && (idx_q >= 16'(ETH_MIN_FRAME - 1))) begin
              ping_id_d = id_cap_q;
              done_d    = 1'b1;
              good_d    = good_q + 64'd1;
            end else begin
              bad_d = bad_q + 64'd1;
            end
            state_d = ST_HEADER;
          end
        end
        ST_DROP: begin
          if (s_axis_tlast)
            state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

  assign rx_ping_id     = ping_id_q;
  assign rx_done        = done_q;
  assign rx_frames_good = good_q;
  assign rx_frames_bad  = bad_q;

endmodule

// File: tb/tb_eth_measurer_rx.sv
// Randomized scoreboard bench for eth_measurer_rx against a frame-level reference model.
module tb_eth_measurer_rx;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [63:0] id;
    logic [63:0] good;
    logic [63:0] bad;
  } exp_t;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETYPE = 16'h5A42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] mac_addr = MAC;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [63:0] rx_ping_id;
  logic        rx_done;
  logic [63:0] rx_frames_good;
  logic [63:0] rx_frames_bad;

  int errors = 0;
  int checks = 0;

  bq_t         mbuf;
  exp_t        exq[$];
  logic [63:0] m_id   = '1;
  logic [63:0] m_good = '0;
  logic [63:0] m_bad  = '0;

  eth_measurer_rx dut (
    .clk            (clk),
    .rst            (rst),
    .mac_addr       (mac_addr),
    .s_axis_tdata   (tdata),
    .s_axis_tvalid  (tvalid),
    .s_axis_tlast   (tlast),
    .s_axis_tuser   (tuser),
    .rx_ping_id     (rx_ping_id),
    .rx_done        (rx_done),
    .rx_frames_good (rx_frames_good),
    .rx_frames_bad  (rx_frames_bad)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = not addressed (ignored), 1 = accepted, 2 = addressed but rejected.
  function automatic int verdict(input bq_t f, input bit user);
    bit uc = 1'b1;
    bit bc = 1'b1;
    if (f.size() <= 14) return 0;
    for (int i = 0; i < 6; i++) begin
      uc &= (f[i] == MAC[47-8*i -: 8]);
      bc &= (f[i] == 8'hFF);
    end
    if (!(uc || bc)) return 0;
    if ({f[12], f[13]} != ETYPE) return 0;
    if (f.size() <= 22) return 2;
    if (user || f.size() < 60) return 2;
    return 1;
  endfunction

  task automatic model_step(input logic [7:0] d, input bit last, input bit user);
    int v;
    logic [63:0] id;
    mbuf.push_back(d);
    if (last) begin
      v = verdict(mbuf, user);
      if (v == 1) begin
        id = '0;
        for (int k = 0; k < 8; k++) id = {id[55:0], mbuf[14+k]};
        m_id = id;
        m_good++;
        exq.push_back('{m_id, m_good, m_bad});
      end else if (v == 2) begin
        m_bad++;
      end
      mbuf.delete();
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    exq.delete();
    m_id   = '1;
    m_good = '0;
    m_bad  = '0;
  endtask

  task automatic idle_beat();
    tvalid = 1'b0;
    tdata  = 8'($urandom);
    tlast  = 1'($urandom);
    tuser  = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit user, input bit do_rst);
    rst    = do_rst;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    tuser  = user;
    @(posedge clk);
    if (do_rst) model_reset();
    else model_step(d, last, user);
    #1;
    rst    = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  function automatic bq_t mk_frame(input logic [47:0] dst, input logic [15:0] et,
                                   input logic [63:0] id, input int len);
    bq_t f;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i < 6) b = dst[47-8*i -: 8];
      else if (i < 12) b = 8'($urandom);
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else if (i < 22) b = id[63-8*(i-14) -: 8];
      else b = 8'($urandom);
      f.push_back(b);
    end
    return f;
  endfunction

  task automatic send_bytes(input bq_t f, input bit user, input int gap_max,
                            input int rst_at, input bit end_frame);
    for (int i = 0; i < f.size(); i++) begin
      bit last;
      last = end_frame && (i == f.size() - 1);
      repeat ($urandom_range(gap_max, 0)) idle_beat();
      beat(f[i], last, last ? user : 1'($urandom), i == rst_at);
    end
  endtask

  task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input logic [63:0] id,
                            input int len, input bit user, input int gap_max);
    send_bytes(mk_frame(dst, et, id, len), user, gap_max, -1, 1'b1);
  endtask

  task automatic check_state(input string tag);
    check64({tag, ".ping_id"}, rx_ping_id, m_id);
    check64({tag, ".good"}, rx_frames_good, m_good);
    check64({tag, ".bad"}, rx_frames_bad, m_bad);
  endtask

  // Every accepted frame must show rx_done on the negedge right after its tlast edge.
  always @(negedge clk) begin
    exp_t e;
    if (exq.size() != 0) begin
      e = exq.pop_front();
      check64("mon.rx_done", {63'd0, rx_done}, 64'd1);
      check64("mon.rx_ping_id", rx_ping_id, e.id);
      check64("mon.rx_frames_good", rx_frames_good, e.good);
      check64("mon.rx_frames_bad", rx_frames_bad, e.bad);
    end else if (rx_done) begin
      check64("mon.rx_done_unexpected", {63'd0, rx_done}, 64'd0);
    end
  end

  initial begin
    bq_t f;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) idle_beat();
    check64("reset.ping_id", rx_ping_id, 64'hFFFF_FFFF_FFFF_FFFF);
    check64("reset.good", rx_frames_good, 64'd0);
    check64("reset.bad", rx_frames_bad, 64'd0);

    send_frame(MAC, ETYPE, 64'd7, 60, 1'b0, 0);
    check64("good.ping_id", rx_ping_id, 64'd7);
    check64("good.count", rx_frames_good, 64'd1);
    check_state("good");

    send_frame(MAC, ETYPE, 64'd8, 60, 1'b1, 0);
    check64("tuser.ping_id", rx_ping_id, 64'd7);
    check64("tuser.bad", rx_frames_bad, 64'd1);
    check_state("tuser");

    send_frame(MAC, 16'h0800, 64'd5, 60, 1'b0, 1);
    check_state("etype");
    send_frame(BCAST, ETYPE, 64'd9, 64, 1'b0, 1);
    check64("bcast.ping_id", rx_ping_id, 64'd9);
    send_frame(MAC, ETYPE, 64'd3, 40, 1'b0, 1);
    check64("runt40.bad", rx_frames_bad, 64'd2);
    check_state("filter");

    // Length boundaries and a destination mixing broadcast and unicast bytes.
    send_frame(MAC, ETYPE, 64'd31, 59, 1'b0, 0);
    send_frame(MAC, ETYPE, 64'd32, 14, 1'b0, 0);
    send_frame(MAC, ETYPE, 64'd33, 15, 1'b0, 0);
    send_frame(MAC, ETYPE, 64'd34, 22, 1'b0, 0);
    send_frame(MAC, ETYPE, 64'd35, 23, 1'b0, 0);
    send_frame(48'hFF_FF_FF_00_00_01, ETYPE, 64'd36, 60, 1'b0, 0);
    check_state("bounds");
    send_frame(MAC, ETYPE, 64'hDEAD_BEEF_0123_4567, 61, 1'b0, 0);
    check_state("long");

    for (int n = 10; n <= 12; n++) send_frame(MAC, ETYPE, 64'(n), 60, 1'b0, 3);
    check64("b2b.ping_id", rx_ping_id, 64'd12);
    check_state("b2b");

    for (int n = 0; n < 40; n++) begin
      logic [47:0] d;
      logic [15:0] et;
      case ($urandom_range(3, 0))
        0: d = MAC;
        1: d = BCAST;
        2: d = 48'hFF_FF_FF_00_00_01;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      et = ($urandom_range(3, 0) != 0) ? ETYPE : 16'($urandom);
      send_frame(d, et, {32'($urandom), 32'($urandom)}, $urandom_range(100, 1),
                 $urandom_range(7, 0) == 0, 2);
    end
    check_state("random");

    f = mk_frame(MAC, ETYPE, 64'd99, 60);
    send_bytes(f[0:17], 1'b0, 1, 17, 1'b0);
    check64("midrst.ping_id", rx_ping_id, 64'hFFFF_FFFF_FFFF_FFFF);
    check64("midrst.good", rx_frames_good, 64'd0);
    check64("midrst.bad", rx_frames_bad, 64'd0);
    send_bytes(f[18:59], 1'b0, 1, -1, 1'b1);
    check_state("tail");
    send_frame(MAC, ETYPE, 64'd20, 60, 1'b0, 1);
    check64("after_rst.ping_id", rx_ping_id, 64'd20);
    check64("after_rst.good", rx_frames_good, 64'd1);
    check_state("after_rst");

    repeat (4) idle_beat();
    check64("scoreboard.drained", 64'(exq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
